ysyx_mc_ctrl: RTL and testbench

Multi-cycle execution sequencer for the ysyx NPC core. It replaces the divide-by-two clock scheme: all state elements run on the single core clock, and this block generates per-instruction write-enable strobes. It steps each instruction through fetch, execute, optional memory access and writeback, using valid/ready handshakes toward the IFU and LSU. It also latches the fetched instruction, detects bus hangs with a watchdog, and halts on ebreak.

---
 rtl/ysyx_mc_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ysyx_mc_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_mc_ctrl.sv
// ysyx_mc_ctrl: multi-cycle sequencer for the NPC core (fetch -> execute -> [mem] -> writeback).
// Latency: 4 cycles per ALU/branch/CSR instruction, 6 per load/store on a zero-wait bus; every bus wait cycle adds one.
// Backpressure: requests are held until ready; a REQ/WAIT state stuck for TIMEOUT_CYCLES cycles trips the watchdog into HALT.
//
// Ports:
//   clk, rst                         core clock, asynchronous active-high reset
//   ifu_req_* / ifu_rsp_*            fetch handshake; ifu_rsp_data is latched into inst
//   is_load, is_store, halt_req      decode results, sampled in EX
//   lsu_req_* / lsu_rsp_valid        memory handshake; lsu_req_we = 1 for stores
//   load_data_en                     capture strobe for the WB load-data register
//   pc_we, rf_we_en, csr_we_en       writeback strobes (single cycle, WB state)
//   inst_retired                     one pulse per retired instruction
//   halted, timeout_err              sticky status, cleared only by reset
//   mcycle, minstret                 performance counters, only when YSYX_MC_PERF_EN is defined
//
// Build option: define YSYX_MC_PERF_EN to add the mcycle/minstret counters and ports.

module ysyx_mc_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req_valid,
  input  logic                 ifu_req_ready,
  input  logic                 ifu_rsp_valid,
  input  logic [WIDTH-1:0]     ifu_rsp_data,
  output logic [WIDTH-1:0]     inst,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 halt_req,
  output logic                 lsu_req_valid,
  output logic                 lsu_req_we,
  input  logic                 lsu_req_ready,
  input  logic                 lsu_rsp_valid,
  output logic                 load_data_en,
  output logic                 pc_we,
  output logic                 rf_we_en,
  output logic                 csr_we_en,
  output logic                 inst_retired,
  output logic                 halted,
  output logic                 timeout_err
`ifdef YSYX_MC_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] mcycle,
  output logic [CNT_WIDTH-1:0] minstret
`endif
);

  // Watchdog only has to reach TIMEOUT_CYCLES-1 before the FSM leaves the state.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IF_REQ,
    S_IF_WAIT,
    S_EX,
    S_LS_REQ,
    S_LS_WAIT,
    S_WB,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  inst_q, inst_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              wd_expired;
  logic              in_bus_state;

  assign wd_expired   = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign in_bus_state = (state_q == S_IF_REQ) || (state_q == S_IF_WAIT) ||
                        (state_q == S_LS_REQ) || (state_q == S_LS_WAIT);

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;

    // In every bus state the exit condition is tested before expiry, so an
    // accept/response arriving on the last allowed cycle still proceeds.
    case (state_q)
      S_IF_REQ: begin
        if (ifu_req_ready) begin
          state_d = S_IF_WAIT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_IF_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_data;
          state_d = S_EX;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EX: begin
        // Decode flags are captured so the memory-phase outputs stay pure
        // functions of registered state.
        is_load_d  = is_load;
        is_store_d = is_store;
        if (halt_req) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (is_load || is_store) begin
          state_d = S_LS_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_LS_REQ: begin
        if (lsu_req_ready) begin
          state_d = S_LS_WAIT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_LS_WAIT: begin
        if (lsu_rsp_valid) begin
          state_d = S_WB;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_WB:    state_d = S_IF_REQ;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF_REQ;
    endcase

    // Watchdog restarts on every state change and idles outside bus states.
    if ((state_d != state_q) || !in_bus_state) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IF_REQ;
      inst_q     <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      wd_q       <= wd_d;
    end
  end

  assign ifu_req_valid = (state_q == S_IF_REQ);
  assign inst          = inst_q;
  assign lsu_req_valid = (state_q == S_LS_REQ);
  assign lsu_req_we    = (state_q == S_LS_REQ) && is_store_q;
  // Load data exists on the bus only in the response cycle, so the capture
  // strobe is qualified by lsu_rsp_valid; everything else is state-decoded.
  assign load_data_en  = (state_q == S_LS_WAIT) && is_load_q && lsu_rsp_valid;
  assign pc_we         = (state_q == S_WB);
  assign rf_we_en      = (state_q == S_WB);
  assign csr_we_en     = (state_q == S_WB);
  assign inst_retired  = (state_q == S_WB);
  assign halted        = halted_q;
  assign timeout_err   = timeout_q;

`ifdef YSYX_MC_PERF_EN
  logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
  logic [CNT_WIDTH-1:0] minstret_q, minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    if (state_q != S_HALT) mcycle_d = mcycle_q + CNT_WIDTH'(1);
    if (state_q == S_WB)   minstret_d = minstret_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
`endif

endmodule

// File: tb/tb_ysyx_mc_ctrl.sv
// tb_ysyx_mc_ctrl: randomized bench for the multi-cycle sequencer.
// Bus responders insert chosen numbers of wait cycles; expected retire timing comes from the cycle budget
// 4 + fetch waits (+ 2 + memory waits for loads/stores).
module tb_ysyx_mc_ctrl;

  localparam int W  = 32;
  localparam int TO = 8;
  localparam int CW = 64;

  localparam int K_ALU  = 0;
  localparam int K_LD   = 1;
  localparam int K_ST   = 2;
  localparam int K_HALT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [W-1:0]  ifu_rsp_data, inst;
  logic          is_load, is_store, halt_req;
  logic          lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic          load_data_en, pc_we, rf_we_en, csr_we_en, inst_retired;
  logic          halted, timeout_err;
`ifdef YSYX_MC_PERF_EN
  logic [CW-1:0] mcycle, minstret;
`endif

  int n_chk = 0;
  int n_err = 0;
  int tot   = 0;   // cycles since reset release (cycle 1 = first)
  int n_ret = 0;   // instructions retired since reset release

  always #5 clk = ~clk;

  ysyx_mc_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .inst(inst),
    .is_load(is_load), .is_store(is_store), .halt_req(halt_req),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .load_data_en(load_data_en), .pc_we(pc_we), .rf_we_en(rf_we_en),
    .csr_we_en(csr_we_en), .inst_retired(inst_retired),
    .halted(halted), .timeout_err(timeout_err)
`ifdef YSYX_MC_PERF_EN
    , .mcycle(mcycle), .minstret(minstret)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = '0;
    is_load = 1'b0; is_store = 1'b0; halt_req = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tot = 0;
    n_ret = 0;
  endtask

  // Runs one instruction; entered and left at a falling edge.
  task automatic run_inst(input int kind, input int wr, input int wp, input int lr,
                          input int lp, input logic [W-1:0] data);
    int  phase = 0, cnt = 0, cyc = 0;
    int  ret_cyc = -1, halt_cyc = -1, ld_cnt = 0, ld_cyc = -1;
    int  ifv = 0, lsv = 0, stray = 0, exp_cyc;
    bit  seen_we = 1'b0;
    bit  ls;
    ls = (kind == K_LD) || (kind == K_ST);
    is_load  = (kind == K_LD);
    is_store = (kind == K_ST);
    halt_req = (kind == K_HALT);
    while (ret_cyc < 0 && halt_cyc < 0 && cyc < 64) begin
      cyc++;
      tot++;
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
      ifu_rsp_data  = $urandom;
      case (phase)
        0: if (ifu_req_valid) begin
             if (cnt == wr) begin
               ifu_req_ready = 1'b1;
               ifu_rsp_valid = $urandom_range(0, 1) == 1;  // must be ignored: same cycle as accept
               phase = 1; cnt = 0;
             end else cnt++;
           end
        1: if (cnt == wp) begin
             ifu_rsp_valid = 1'b1; ifu_rsp_data = data; phase = 2; cnt = 0;
           end else cnt++;
        2: if (lsu_req_valid) begin
             if (!seen_we) begin
               chk("lsu_req_we", lsu_req_we, kind == K_ST);
               seen_we = 1'b1;
             end
             if (cnt == lr) begin
               lsu_req_ready = 1'b1;
               lsu_rsp_valid = $urandom_range(0, 1) == 1;
               phase = 3; cnt = 0;
             end else cnt++;
           end
        3: if (cnt == lp) begin
             lsu_rsp_valid = 1'b1; phase = 4;
           end else cnt++;
        default: ;
      endcase
      #1;
      if (ifu_req_valid) ifv++;
      if (lsu_req_valid) lsv++;
      if (load_data_en) begin ld_cnt++; ld_cyc = cyc; end
      if (halted || timeout_err) begin
        halt_cyc = cyc;
      end else if (inst_retired) begin
        ret_cyc = cyc;
        chk("wb_strobes", {pc_we, rf_we_en, csr_we_en}, 3'b111);
`ifdef YSYX_MC_PERF_EN
        chk("mcycle", mcycle, tot - 1);
        chk("minstret", minstret, n_ret);
`endif
        n_ret++;
      end else if (pc_we || rf_we_en || csr_we_en) begin
        stray++;
      end
      @(negedge clk);
    end
    ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0; ifu_req_ready = 1'b0; lsu_req_ready = 1'b0;
    if (kind == K_HALT) begin
      chk("halt_cycle", halt_cyc, 4 + wr + wp);
      chk("halted", halted, 1'b1);
      chk("halt_no_timeout", timeout_err, 1'b0);
    end else begin
      exp_cyc = 4 + wr + wp + (ls ? 2 + lr + lp : 0);
      chk("retire_cycle", ret_cyc, exp_cyc);
      chk("inst_latched", inst, data);
      chk("load_data_en_cnt", ld_cnt, kind == K_LD);
      if (kind == K_LD) chk("load_data_en_cyc", ld_cyc, exp_cyc - 1);
      chk("lsu_vld_cycles", lsv, ls ? lr + 1 : 0);
      chk("no_timeout", timeout_err, 1'b0);
    end
    chk("ifu_vld_cycles", ifv, wr + 1);
    chk("stray_strobes", stray, 0);
  endtask

  // After HALT/timeout nothing may be requested or strobed.
  task automatic check_quiet(input string tag);
    int busy = 0;
`ifdef YSYX_MC_PERF_EN
    logic [CW-1:0] mc0;
    mc0 = mcycle;
`endif
    repeat (5) begin
      #1;
      if (ifu_req_valid || lsu_req_valid || pc_we || rf_we_en || csr_we_en || inst_retired || load_data_en)
        busy++;
      @(negedge clk);
    end
    chk(tag, busy, 0);
`ifdef YSYX_MC_PERF_EN
    chk("mcycle_frozen", mcycle, mc0);
`endif
  endtask

  initial begin
    int kind;
    clr_inputs();
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inst", inst, 0);
    chk("rst_status", {halted, timeout_err}, 2'b00);
    chk("rst_strobes", {pc_we, rf_we_en, csr_we_en, inst_retired, load_data_en, lsu_req_valid}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_ifu_req_valid", ifu_req_valid, 1'b1);
    @(negedge clk);
    // Resync: one cycle was spent in IF_REQ without ready.
    do_reset();

    // Directed: 3 x addi, load with waits, store.
    repeat (3) run_inst(K_ALU, 0, 0, 0, 0, 32'h0010_0093);
    run_inst(K_LD, 0, 0, 2, 3, 32'h0000_a103);
    run_inst(K_ST, 0, 0, 0, 0, 32'h0020_a023);

    // Random stream; waits up to TO-1 exercise the exit-wins-over-expiry edge.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      run_inst(kind, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
    end

    // Ebreak from a fresh reset, zero-wait.
    do_reset();
    run_inst(K_HALT, 0, 0, 0, 0, 32'h0010_0073);
`ifdef YSYX_MC_PERF_EN
    chk("mcycle_at_halt", mcycle, 3);
`endif
    check_quiet("halt_quiet");

    // Watchdog: ready held low in IF_REQ.
    do_reset();
    for (int i = 1; i <= TO; i++) begin
      #1;
      if (i == TO) chk("wd_before_expiry", {timeout_err, ifu_req_valid}, 2'b01);
      @(negedge clk);
    end
    #1;
    chk("wd_timeout_err", timeout_err, 1'b1);
    chk("wd_not_halted_flag", halted, 1'b0);
    @(negedge clk);
    check_quiet("timeout_quiet");

    // Ready on the last allowed cycle: no error.
    do_reset();
    run_inst(K_ALU, TO - 1, 0, 0, 0, 32'h1234_5678);

    // Reset pulsed while in LS_WAIT.
    do_reset();
    is_load = 1'b1;
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'hdead_0003;
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    @(negedge clk);
    lsu_req_ready = 1'b1;
    @(negedge clk);
    lsu_req_ready = 1'b0;
    #1;
    chk("lsw_inst", inst, 32'hdead_0003);
    chk("lsw_no_req", {ifu_req_valid, lsu_req_valid}, 2'b00);
    rst = 1'b1;
    lsu_rsp_valid = 1'b1;
    #1;
    chk("midrst_strobes", {pc_we, rf_we_en, csr_we_en, inst_retired, load_data_en}, 5'b0);
    chk("midrst_inst", inst, 0);
    @(negedge clk);
    #1;
    chk("midrst_strobes_hold", {pc_we, rf_we_en, csr_we_en, inst_retired, load_data_en}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    lsu_rsp_valid = 1'b0;
    tot = 0;
    n_ret = 0;
    #1;
    chk("midrst_ifu_req_valid", ifu_req_valid, 1'b1);
`ifdef YSYX_MC_PERF_EN
    chk("midrst_counters", {mcycle, minstret}, 128'b0);
`endif
    run_inst(K_ALU, 0, 0, 0, 0, 32'h0000_0013);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
